// File: rtl/offnariscv_pkg.sv
// Shared types for the writeback slice: the register-file result record and execution-unit indices.
package offnariscv_pkg;

   localparam int XLEN = 32;

   localparam int EU_ALU = 0;
   localparam int EU_LSU = 1;
   localparam int EU_CSR = 2;

   typedef struct packed {
      logic [4:0] rd;
   } id_data_t;

   typedef struct packed {
      id_data_t id_data;
   } rf_data_t;

   typedef struct packed {
      rf_data_t rf_data;
   } ex_data_t;

   // One completed result; every execution unit produces this same record.
   typedef struct packed {
      ex_data_t         ex_data;
      logic [XLEN-1:0]  wdata;
   } wbrf_tdata_t;

   // Cyclic index (base + off) mod n, valid for base < n and off < n.
   function automatic int rr_wrap(input int base, input int off, input int n);
      int sum;
      sum = base + off;
      if (sum >= n) begin
         sum = sum - n;
      end
      return sum;
   endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream style valid/ready/data bundle used between pipeline stages.
interface axis_if #(
   parameter int DATA_W = $bits(offnariscv_pkg::wbrf_tdata_t)
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;

   modport m (output tvalid, output tdata, input tready);
   modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/wb_rr_arbiter.sv
// Grant selector for the writeback stage: round-robin with a rotating pointer by default,
// or fixed priority (highest index wins) when WB_FIXED_PRIO_EN is defined.
module wb_rr_arbiter
   import offnariscv_pkg::*;
#(
   parameter int NUM_EU = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_EU-1:0] req,
   input  logic              advance,
   output logic [NUM_EU-1:0] grant
);

`ifdef WB_FIXED_PRIO_EN

   // Ascending scan lets the highest-index requester overwrite any lower one.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_EU; i++) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end

   logic unused_fixed;
   assign unused_fixed = ^{clk, rst, advance};

`else

   localparam int PW = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] grant_idx;
   logic          found;
   int            scan_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      scan_idx  = 0;
      for (int k = 0; k < NUM_EU; k++) begin
         scan_idx = rr_wrap(int'(rr_ptr_q), k, NUM_EU);
         if (!found && req[scan_idx]) begin
            found           = 1'b1;
            grant_idx       = PW'(scan_idx);
            grant[scan_idx] = 1'b1;
         end
      end
      rr_ptr_d = rr_ptr_q;
      // The pointer only moves on an actual handshake, to the slot after the winner.
      if (advance && found) begin
         rr_ptr_d = PW'(rr_wrap(int'(grant_idx), 1, NUM_EU));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

`endif

endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates ALU/LSU/CSR results into one registered stream for the register file.
// Build option WB_FIXED_PRIO_EN selects fixed CSR > LSU > ALU priority instead of round-robin.
module writeback
   import offnariscv_pkg::*;
#(
   parameter int NUM_EU    = 3,
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   axis_if.s                    alu_axis_if,
   axis_if.s                    lsu_axis_if,
   axis_if.s                    csr_axis_if,
   axis_if.m                    wbrf_axis_if,
   input  logic                 invalidate,
   output logic                 retire,
   output logic [CNT_WIDTH-1:0] instret
);

   logic [NUM_EU-1:0]    req;
   logic [NUM_EU-1:0]    grant;
   logic [NUM_EU-1:0]    eu_tready;
   wbrf_tdata_t          eu_tdata [NUM_EU];
   wbrf_tdata_t          sel_data;

   logic                 load_en;
   logic                 in_hs;
   logic                 out_hs;

   logic                 out_valid_q, out_valid_d;
   wbrf_tdata_t          out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;

   assign req[EU_ALU]      = alu_axis_if.tvalid;
   assign req[EU_LSU]      = lsu_axis_if.tvalid;
   assign req[EU_CSR]      = csr_axis_if.tvalid;
   assign eu_tdata[EU_ALU] = alu_axis_if.tdata;
   assign eu_tdata[EU_LSU] = lsu_axis_if.tdata;
   assign eu_tdata[EU_CSR] = csr_axis_if.tdata;

   assign alu_axis_if.tready = eu_tready[EU_ALU];
   assign lsu_axis_if.tready = eu_tready[EU_LSU];
   assign csr_axis_if.tready = eu_tready[EU_CSR];

   // rst is folded in so EU treadys drop as soon as reset asserts, not at the next edge.
   assign load_en = rst && (!out_valid_q || wbrf_axis_if.tready) && !invalidate;
   assign out_hs  = out_valid_q && wbrf_axis_if.tready;
   assign in_hs   = load_en && (|req);

   wb_rr_arbiter #(
      .NUM_EU (NUM_EU)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (in_hs),
      .grant   (grant)
   );

   generate
      for (genvar gi = 0; gi < NUM_EU; gi++) begin : g_eu_tready
         assign eu_tready[gi] = grant[gi] && load_en;
      end
   endgenerate

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_EU; i++) begin
         if (grant[i]) begin
            sel_data = eu_tdata[i];
         end
      end
   end

   // A result leaving on the same edge as a flush still retires: the register file commits it.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      instret_d   = instret_q + {{(CNT_WIDTH-1){1'b0}}, out_hs};
      if (invalidate) begin
         out_valid_d = 1'b0;
      end else if (in_hs) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         instret_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         instret_q   <= instret_d;
      end
   end

   assign wbrf_axis_if.tvalid = out_valid_q;
   assign wbrf_axis_if.tdata  = out_data_q;
   assign retire              = out_hs;
   assign instret             = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus randomized traffic against a queue model.
module tb_writeback;
   import offnariscv_pkg::*;

   localparam int W  = $bits(wbrf_tdata_t);
   localparam int CW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          invalidate = 1'b0;
   logic          wt = 1'b1;
   logic          retire;
   logic [CW-1:0] instret;
   logic [2:0]    v = 3'b000;
   wbrf_tdata_t   d [3];
   logic [2:0]    trdy;
   wbrf_tdata_t   wb_out;

   axis_if #(.DATA_W(W)) alu_if ();
   axis_if #(.DATA_W(W)) lsu_if ();
   axis_if #(.DATA_W(W)) csr_if ();
   axis_if #(.DATA_W(W)) wbrf_if ();

   assign alu_if.tvalid  = v[0];
   assign lsu_if.tvalid  = v[1];
   assign csr_if.tvalid  = v[2];
   assign alu_if.tdata   = d[0];
   assign lsu_if.tdata   = d[1];
   assign csr_if.tdata   = d[2];
   assign wbrf_if.tready = wt;
   assign trdy           = {csr_if.tready, lsu_if.tready, alu_if.tready};
   assign wb_out         = wbrf_if.tdata;

   writeback #(.NUM_EU(3), .CNT_WIDTH(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_axis_if  (alu_if),
      .lsu_axis_if  (lsu_if),
      .csr_axis_if  (csr_if),
      .wbrf_axis_if (wbrf_if),
      .invalidate   (invalidate),
      .retire       (retire),
      .instret      (instret)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: the output register seen as a queue of at most one result.
   wbrf_tdata_t   m_q [$];
   int            m_ptr = 0;
   logic [CW-1:0] m_cnt = '0;
   logic          preload_req = 1'b0;
   logic [2:0]    hs_seen = 3'b000;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic wbrf_tdata_t mk(input logic [4:0] rd, input logic [31:0] w);
      wbrf_tdata_t r;
      r = '0;
      r.ex_data.rf_data.id_data.rd = rd;
      r.wdata = w;
      return r;
   endfunction

   function automatic int model_grant(input logic [2:0] r, input int ptr);
      int g;
      g = -1;
`ifdef WB_FIXED_PRIO_EN
      for (int i = 0; i < 3; i++) begin
         if (r[i]) g = i;
      end
      if (ptr < 0) g = -1;
`else
      for (int k = 2; k >= 0; k--) begin
         if (r[(ptr + k) % 3]) g = (ptr + k) % 3;
      end
`endif
      return g;
   endfunction

   always @(negedge clk) begin : compare
      int         g;
      logic       load;
      logic       exp_valid;
      logic       exp_ret;
      logic [2:0] exp_trdy;
      if (preload_req) m_cnt = '1;
      g         = model_grant(v, m_ptr);
      exp_valid = rst && (m_q.size() != 0);
      load      = rst && ((m_q.size() == 0) || wt) && !invalidate;
      exp_trdy  = (load && g >= 0) ? 3'(1 << g) : 3'b000;
      exp_ret   = exp_valid && wt;
      chk("tvalid", wbrf_if.tvalid, exp_valid);
      if (exp_valid) chk("tdata", wbrf_if.tdata, m_q[0]);
      chk("retire", retire, exp_ret);
      chk("instret", instret, rst ? m_cnt : '0);
      chk("eu_tready", trdy, exp_trdy);
      hs_seen = v & trdy;
      if (!rst) begin
         m_q.delete();
         m_ptr = 0;
         m_cnt = '0;
      end else begin
         if (exp_ret) begin
            m_cnt = m_cnt + 1;
            void'(m_q.pop_front());
         end
         if (invalidate) begin
            m_q.delete();
         end else if (load && g >= 0) begin
            m_q.push_back(d[g]);
            m_ptr = (g + 1) % 3;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) d[i] = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_tvalid", wbrf_if.tvalid, 1'b0);
      chk("rst_instret", instret, 64'd0);
      chk("rst_tready", trdy, 3'b000);
      chk("rst_retire", retire, 1'b0);
      tick();
      tick();
      rst = 1'b1;

      // Single ALU result
      d[0] = mk(5'd5, 32'hDEADBEEF);
      v    = 3'b001;
      #1;
      chk("t1_alu_tready", trdy, 3'b001);
      tick();
      v = 3'b000;
      #1;
      chk("t1_tvalid", wbrf_if.tvalid, 1'b1);
      chk("t1_rd", wb_out.ex_data.rf_data.id_data.rd, 5'd5);
      chk("t1_wdata", wb_out.wdata, 32'hDEADBEEF);
      chk("t1_retire", retire, 1'b1);
      tick();
      chk("t1_instret", instret, 64'd1);

      // All three EUs requesting for six cycles
      do_reset();
      for (int i = 0; i < 3; i++) d[i] = mk(5'(i + 1), 32'h1000 + i);
      v = 3'b111;
      for (int c = 0; c < 6; c++) begin
         logic [2:0] eg;
         logic [4:0] erd;
`ifdef WB_FIXED_PRIO_EN
         eg  = 3'b100;
         erd = 5'd3;
`else
         eg  = 3'b001 << (c % 3);
         erd = 5'((c % 3) + 1);
`endif
         #1;
         chk("t2_grant", trdy, eg);
         tick();
         chk("t2_rd", wb_out.ex_data.rf_data.id_data.rd, erd);
      end
      v = 3'b000;
      tick();
      chk("t2_instret", instret, 64'd6);

      // Output stall with LSU waiting
      wt   = 1'b0;
      d[0] = mk(5'd7, 32'hA5A50001);
      v    = 3'b001;
      tick();
      d[1] = mk(5'd9, 32'h5A5A0002);
      v    = 3'b010;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t3_stall_tvalid", wbrf_if.tvalid, 1'b1);
         chk("t3_stall_lsu_tready", trdy[1], 1'b0);
         chk("t3_stall_wdata", wb_out.wdata, 32'hA5A50001);
         tick();
      end
      wt = 1'b1;
      #1;
      chk("t3_release_grant", trdy, 3'b010);
      chk("t3_release_retire", retire, 1'b1);
      tick();
      v = 3'b000;
      #1;
      chk("t3_lsu_wdata", wb_out.wdata, 32'h5A5A0002);
      chk("t3_lsu_rd", wb_out.ex_data.rf_data.id_data.rd, 5'd9);

      // Flush while stalled
      wt         = 1'b0;
      invalidate = 1'b1;
      d[2]       = mk(5'd11, 32'h0000C0DE);
      v          = 3'b100;
      #1;
      chk("t4_inval_tready", trdy, 3'b000);
      chk("t4_inval_retire", retire, 1'b0);
      tick();
      invalidate = 1'b0;
      #1;
      chk("t4_tvalid_cleared", wbrf_if.tvalid, 1'b0);
      chk("t4_instret_held", instret, 64'd7);
      wt = 1'b1;
      tick();
      v = 3'b000;
      #1;
      chk("t4_csr_wdata", wb_out.wdata, 32'h0000C0DE);
      tick();
      chk("t4_instret_after", instret, 64'd8);

      // Counter wrap from all-ones
      preload_req = 1'b1;
      force dut.instret_q = '1;
      tick();
      release dut.instret_q;
      preload_req = 1'b0;
      #1;
      chk("t5_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      d[0] = mk(5'd1, 32'h1);
      v    = 3'b001;
      tick();
      v = 3'b000;
      tick();
      chk("t5_wrap", instret, 64'd0);

      // Asynchronous reset in the middle of a stall
      wt   = 1'b0;
      d[1] = mk(5'd13, 32'h0000BEEF);
      v    = 3'b010;
      tick();
      d[0] = mk(5'd14, 32'h00001234);
      v    = 3'b001;
      #2;
      rst = 1'b0;
      #1;
      chk("t6_async_tvalid", wbrf_if.tvalid, 1'b0);
      chk("t6_async_instret", instret, 64'd0);
      chk("t6_async_tready", trdy, 3'b000);
      wt = 1'b1;
      tick();
      chk("t6_tready_in_rst", trdy, 3'b000);
      v = 3'b000;
      tick();
      rst = 1'b1;

      // Randomized traffic; EU sources hold tvalid/tdata until accepted
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 3; i++) begin
            if (!v[i] || hs_seen[i]) begin
               v[i] = ($urandom_range(0, 99) < 55);
               d[i] = mk(5'($urandom_range(0, 31)), $urandom);
            end
         end
         wt         = ($urandom_range(0, 99) < 70);
         invalidate = ($urandom_range(0, 99) < 8);
         tick();
      end
      v          = 3'b000;
      invalidate = 1'b0;
      wt         = 1'b1;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
